mac_pipelined: RTL and testbench
================================

// Module: mac_pipelined
// PURPOSE
//  Parametrised, pipelined multiply-accumulate unit; successor to the fixed 4x4->9-bit MAC.
//  Streams operand pairs over a valid/ready handshake and accumulates them over a vector
//  delimited by 'last'. Each vector produces one result, held under valid/ready backpressure.
//  Adds signed mode, saturate-or-wrap mode and a sticky overflow flag.
//  Sits between the operand sequencer and the result collector of the datapath.
// PARAMETERS
//  IN_W      4   operand width, a and b
//  ACC_W     9   accumulator/result width; must be >= 2*IN_W
//  SIGNED    0   1: two's-complement operands and accumulator; 0: unsigned
//  SATURATE  1   1: clamp accumulator at its range limits; 0: wrap modulo 2^ACC_W
//  CNT_W     8   width of the beat counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      beat accepted when in_valid & in_ready
//  a          in   IN_W   multiplicand
//  b          in   IN_W   multiplier
//  last       in   1      beat is the final term of the current vector
//  acc        out  ACC_W  running accumulator, updated every accumulate cycle
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  result     out  ACC_W  completed vector sum; stable while out_valid
//  ovf        out  1      overflow/saturation occurred in this result's vector
//  beats      out  CNT_W  number of beats in this result's vector; saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready. Pipeline valids, acc, result, ovf and beats are
//    cleared. Beats presented while rst=1 are discarded.
//  - in_ready depends only on registered state, with no path from in_valid.
//  - Stage 1, edge after accept: p = a*b, 2*IN_W bits. Stage 2 adds p, sign- or zero-extended
//    to ACC_W, into acc.
//  - Latency: beat accepted at edge N updates acc at edge N+2. When that beat has last=1,
//    out_valid rises after edge N+2.
//  - First beat of a vector: after reset or after a last beat, stage 2 uses 0 as the addend
//    base, not acc. Back-to-back vectors therefore need no bubble.
//  - The last beat loads result, ovf and beats, and sets out_valid.
//    acc keeps the final sum until the next vector's first beat.
//  - Overflow, SATURATE=1: clamp to the range limit.
//    Unsigned range is [0, 2^ACC_W-1]; signed range is [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//  - Overflow, SATURATE=0: wrap. In both modes the internal sticky flag is set and is cleared
//    at the first beat of the next vector.
//  - Result handshake: out_valid clears on out_valid & out_ready unless a new result loads on
//    the same edge. A new result loading on that edge keeps out_valid at 1.
//  - Stall condition: stage 1 holds a last beat, out_valid=1 and out_ready=0. While stalled,
//    stage 1 holds, stage 2 does not update and in_ready=0. No data is lost or duplicated.
//  - Non-last beats never stall.
//  - Reset mid-vector: the partial sum is discarded. The next accepted beat starts a new vector.
// STRUCTURE
//  - Shared package mac_pkg:
//    sat_add function (width, signed and saturate generic);
//    ext function (sign- or zero-extend to ACC_W);
//    localparams ACC_MAX and ACC_MIN per mode.
//  - Sub-module mac_mult_stage: registered IN_W x IN_W multiplier with valid/last/hold sideband.
//  - Top level: accumulate stage, result register, stall logic.
// TESTING (IN_W=4, ACC_W=9 unless noted)
//  1. Unsigned, SATURATE=1. Beats (9,10),(12,2),(9,2),(5,4 last), out_ready=1
//     -> result=152, beats=4, ovf=0; out_valid 2 cycles after last accept.
//  2. Unsigned, SATURATE=1. Beats (15,15)x3, last on the 3rd
//     -> result=511, ovf=1. Same stimulus with SATURATE=0 -> result=163, ovf=1.
//  3. SIGNED=1. Beats (4'b1001,2),(4'b1110,2 last), i.e. -7*2 + -2*2
//     -> result=9'h1EE (-18), ovf=0.
//  4. out_ready=0. Two single-beat vectors (3,3 last),(2,5 last)
//     -> result=9, out_valid held; in_ready=0 while the 2nd last beat waits.
//     Raising out_ready -> result=10 the next cycle, then out_valid=0.
//  5. Accept (9,2),(5,4), pulse rst 1 cycle, then (5,4 last)
//     -> result=20, beats=1; all outputs 0 during reset.
//  6. Back-to-back vectors (1,1 last),(2,2 last),(3,3 last), out_ready=1
//     -> results 1,4,9 on consecutive cycles; in_ready=1 throughout.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared extension and saturating-add helpers for the pipelined MAC.
package mac_pkg;
   function automatic logic [63:0] mask(input int w);
      return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
   endfunction
   function automatic logic [63:0] acc_max(input int w, input bit sgn);
      return sgn ? (64'd1 << (w - 1)) - 64'd1 : mask(w);
   endfunction
   function automatic logic [63:0] acc_min(input int w, input bit sgn);
      return sgn ? ~acc_max(w, sgn) : 64'd0;
   endfunction
   function automatic logic [63:0] sext(input logic [63:0] x, input int w);
      return x[w-1] ? (x | ~mask(w)) : (x & mask(w));
   endfunction
   function automatic logic [63:0] ext(input logic [63:0] x, input int w, input bit sgn);
      return sgn ? sext(x, w) : (x & mask(w));
   endfunction
   // Operands are w-bit values; the sum is formed in 64 bits so the true result is visible
   function automatic logic [63:0] sat_add(input logic [63:0] x, input logic [63:0] y,
                                           input int w, input bit sgn, input bit sat,
                                           output logic ovf);
      logic [63:0] s, hi, lo;
      logic over, under;
      s = ext(x, w, sgn) + ext(y, w, sgn);
      hi = acc_max(w, sgn);
      lo = acc_min(w, sgn);
      over = sgn ? ($signed(s) > $signed(hi)) : (s > hi);
      under = sgn && ($signed(s) < $signed(lo));
      ovf = over | under;
      return ((!ovf || !sat) ? s : (over ? hi : lo)) & mask(w);
   endfunction
endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: operand register followed by a registered product, with valid/last sideband.
module mac_mult_stage
   import mac_pkg::*;
#(
   parameter int IN_W   = 4,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              in_valid,
   input  logic [IN_W-1:0]   a,
   input  logic [IN_W-1:0]   b,
   input  logic              last,
   output logic              v,
   output logic              l,
   output logic [2*IN_W-1:0] p
);
   logic              v0, l0;
   logic [IN_W-1:0]   a0, b0;
   logic signed [2*IN_W-1:0] ps;
   logic [2*IN_W-1:0] pu;
   assign ps = $signed(a0) * $signed(b0);
   assign pu = a0 * b0;
   always_ff @(posedge clk) begin
      if (rst) begin
         v0 <= 1'b0;
         l0 <= 1'b0;
         a0 <= '0;
         b0 <= '0;
         v  <= 1'b0;
         l  <= 1'b0;
         p  <= '0;
      end else if (!hold) begin
         v0 <= in_valid;
         l0 <= last;
         a0 <= a;
         b0 <= b;
         v  <= v0;
         l  <= l0;
         p  <= (SIGNED != 0) ? $unsigned(ps) : pu;
      end
   end
endmodule

// File: rtl/mac_pipelined.sv
// mac_pipelined: streaming multiply-accumulate over last-delimited vectors with held results.
// ACC_W must lie in [2*IN_W, 63].
module mac_pipelined
   import mac_pkg::*;
#(
   parameter int IN_W     = 4,
   parameter int ACC_W    = 9,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   input  logic             last,
   output logic [ACC_W-1:0] acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             ovf,
   output logic [CNT_W-1:0] beats
);
   logic              v1, l1, stall, upd, first, stk, stk_n, o;
   logic [2*IN_W-1:0] p1;
   logic [ACC_W-1:0]  base, sum;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [63:0]       t;
   // A finished vector sum waiting on a full result register blocks the whole pipe
   assign stall = v1 & l1 & out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign upd = v1 & ~stall;
   mac_mult_stage #(.IN_W(IN_W), .SIGNED(SIGNED)) u_mult (
      .clk(clk), .rst(rst), .hold(stall), .in_valid(in_valid & in_ready),
      .a(a), .b(b), .last(last), .v(v1), .l(l1), .p(p1)
   );
   always_comb begin
      base = first ? '0 : acc;
      o = 1'b0;
      t = sat_add({{(64-ACC_W){1'b0}}, base},
                  ext({{(64-2*IN_W){1'b0}}, p1}, 2*IN_W, SIGNED != 0),
                  ACC_W, SIGNED != 0, SATURATE != 0, o);
      sum = t[ACC_W-1:0];
      stk_n = (stk & ~first) | o | (|t[63:ACC_W]);
      cnt_n = first ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         stk       <= 1'b0;
         cnt       <= '0;
         first     <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         beats     <= '0;
      end else begin
         if (upd) begin
            acc   <= sum;
            stk   <= stk_n;
            cnt   <= cnt_n;
            first <= l1;
         end
         if (upd & l1) begin
            result    <= sum;
            ovf       <= stk_n;
            beats     <= cnt_n;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mac_pipelined.sv
// tb_mac_pipelined: directed vectors against unsigned-saturate, unsigned-wrap and signed MACs.
module tb_mac_pipelined;
   logic clk = 1'b0, rst, in_valid, last, out_ready;
   logic [3:0] a, b;
   logic       rdy_o [3];
   logic       ov    [3];
   logic       ovf_o [3];
   logic [8:0] acc_o [3];
   logic [8:0] res   [3];
   logic [7:0] bts   [3];
   int nchk = 0, nerr = 0, w;
   always #5 clk = ~clk;
   mac_pipelined #(.SIGNED(0), .SATURATE(1)) u_us (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[0]), .a(a), .b(b),
      .last(last), .acc(acc_o[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res[0]), .ovf(ovf_o[0]), .beats(bts[0]));
   mac_pipelined #(.SIGNED(0), .SATURATE(0)) u_wr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[1]), .a(a), .b(b),
      .last(last), .acc(acc_o[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res[1]), .ovf(ovf_o[1]), .beats(bts[1]));
   mac_pipelined #(.SIGNED(1), .SATURATE(1)) u_sg (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[2]), .a(a), .b(b),
      .last(last), .acc(acc_o[2]), .out_valid(ov[2]), .out_ready(out_ready),
      .result(res[2]), .ovf(ovf_o[2]), .beats(bts[2]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic beat(input logic [3:0] x, input logic [3:0] y, input logic l, output int n);
      a = x;
      b = y;
      last = l;
      in_valid = 1'b1;
      n = 0;
      while (!rdy_o[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_o[0]) check("beat_timeout", rdy_o[0], 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      last = 1'b0;
   endtask
   task automatic wait_out(input string tag);
      for (int k = 0; k < 20 && !ov[0]; k++) @(negedge clk);
      check(tag, ov[0], 1);
   endtask
   initial begin
      rst = 1'b1; in_valid = 1'b0; last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", ov[0], 0);
      check("rst_acc", acc_o[0], 0);
      check("rst_result", res[0], 0);
      check("rst_beats", bts[0], 0);
      check("rst_ovf", ovf_o[0], 0);
      check("rst_ready", rdy_o[0], 1);
      rst = 1'b0;
      beat(9, 10, 0, w); beat(12, 2, 0, w); beat(9, 2, 0, w); beat(5, 4, 1, w);
      @(negedge clk) check("t1_lat0", ov[0], 0);
      @(negedge clk) check("t1_lat1", ov[0], 0);
      @(negedge clk) check("t1_lat2", ov[0], 1);
      check("t1_result", res[0], 152);
      check("t1_beats", bts[0], 4);
      check("t1_ovf", ovf_o[0], 0);
      @(negedge clk);
      check("t1_clear", ov[0], 0);
      check("t1_acc_hold", acc_o[0], 152);
      beat(15, 15, 0, w); beat(15, 15, 0, w); beat(15, 15, 1, w);
      wait_out("t2_valid");
      check("t2_sat_result", res[0], 511);
      check("t2_sat_ovf", ovf_o[0], 1);
      check("t2_beats", bts[0], 3);
      check("t2_wrap_result", res[1], 163);
      check("t2_wrap_ovf", ovf_o[1], 1);
      beat(4'b1001, 2, 0, w); beat(4'b1110, 2, 1, w);
      wait_out("t3_valid");
      check("t3_result", res[2], 9'h1EE);
      check("t3_ovf", ovf_o[2], 0);
      check("t3_clr_ovf", ovf_o[0], 0);
      @(negedge clk);
      check("t3_clear", ov[0], 0);
      out_ready = 1'b0;
      beat(3, 3, 1, w); beat(2, 5, 1, w);
      repeat (4) @(negedge clk);
      check("t4_held", ov[0], 1);
      check("t4_result", res[0], 9);
      check("t4_stall", rdy_o[0], 0);
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_valid2", ov[0], 1);
      check("t4_result2", res[0], 10);
      check("t4_ready", rdy_o[0], 1);
      @(negedge clk) check("t4_clear", ov[0], 0);
      beat(9, 2, 0, w); beat(5, 4, 0, w);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_acc", acc_o[0], 0);
      check("t5_rst_valid", ov[0], 0);
      check("t5_rst_result", res[0], 0);
      check("t5_rst_beats", bts[0], 0);
      rst = 1'b0;
      beat(5, 4, 1, w);
      wait_out("t5_valid");
      check("t5_result", res[0], 20);
      check("t5_beats", bts[0], 1);
      check("t5_ovf", ovf_o[0], 0);
      @(negedge clk);
      beat(1, 1, 1, w); check("t6_rdy0", w, 0);
      beat(2, 2, 1, w); check("t6_rdy1", w, 0);
      beat(3, 3, 1, w); check("t6_rdy2", w, 0);
      check("t6_v0", ov[0], 1);
      check("t6_r0", res[0], 1);
      @(posedge clk);
      #1 check("t6_r1", res[0], 4);
      check("t6_v1", ov[0], 1);
      @(posedge clk);
      #1 check("t6_r2", res[0], 9);
      check("t6_b2", bts[0], 1);
      @(posedge clk);
      #1 check("t6_done", ov[0], 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
